// File: rtl/inst_rom_server_pkg.sv
// Shared constants and loader state type for the instruction ROM server.
// The fetch bus widths and the NOP encoding match the core's fetch port.
package inst_rom_server_pkg;

  localparam int          INST_ADDR_W = 32;
  localparam int          INST_W      = 32;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_RUN  = 2'd2
  } ld_state_e;

endpackage

// File: rtl/inst_rom_server_packer.sv
// Assembles loader bytes little-endian into 32-bit words and strobes each
// completed word, or the partial word that carries the final byte.
module inst_rom_server_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  input  logic        last_i,
  output logic [31:0] word_o,
  output logic        word_strobe_o
);

  logic [1:0]  byte_cnt_q;
  logic [31:0] shift_q;

  // The word seen on a strobe already includes the byte accepted that cycle,
  // and lanes not yet written stay zero because shift_q clears on each commit.
  always_comb begin
    word_o = shift_q;
    case (byte_cnt_q)
      2'd0:    word_o[7:0]   = byte_i;
      2'd1:    word_o[15:8]  = byte_i;
      2'd2:    word_o[23:16] = byte_i;
      default: word_o[31:24] = byte_i;
    endcase
    word_strobe_o = accept_i && ((byte_cnt_q == 2'd3) || last_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_q <= 2'd0;
      shift_q    <= 32'h0;
    end else if (accept_i) begin
      if (word_strobe_o) begin
        byte_cnt_q <= 2'd0;
        shift_q    <= 32'h0;
      end else begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        shift_q    <= word_o;
      end
    end
  end

endmodule

// File: rtl/inst_rom_server.sv
// Instruction ROM server: boot-time byte loader fills a word array, then the
// core is released and fetches are answered combinationally from the array.
module inst_rom_server
  import inst_rom_server_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rom_ce,
  input  logic [INST_ADDR_W-1:0]  rom_addr,
  output logic [INST_W-1:0]       rom_inst,
  input  logic                    ld_valid,
  input  logic [7:0]              ld_byte,
  input  logic                    ld_last,
  output logic                    ld_ready,
  output logic                    cpu_hold,
  output logic [DEPTH_LOG2:0]     load_words,
  output logic [1:0]              err_flags,
  output ld_state_e               dbg_state
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  // Loader handshake: a byte transfers on every rising edge where
  // ld_valid && ld_ready; ld_ready depends on state only, never on ld_valid.

  ld_state_e             state_q, state_d;
  logic [DEPTH_LOG2:0]   word_ptr_q, word_ptr_d;
  logic [DEPTH_LOG2:0]   load_words_q, load_words_d;
  logic [1:0]            err_q, err_d;
  logic                  hold_q;

  logic                  accept;
  logic [31:0]           pack_word;
  logic                  pack_strobe;
  logic                  mem_we;
  logic [31:0]           offset;
  logic [31:0]           word_idx;
  logic                  misaligned;
  logic                  in_image;

  logic [31:0] mem [0:DEPTH-1];

  assign accept = (state_q == LD_LOAD) && ld_valid;

  inst_rom_server_packer u_packer (
    .clk           (clk),
    .rst           (rst),
    .accept_i      (accept),
    .byte_i        (ld_byte),
    .last_i        (ld_last),
    .word_o        (pack_word),
    .word_strobe_o (pack_strobe)
  );

  always_comb begin
    state_d      = state_q;
    word_ptr_d   = word_ptr_q;
    load_words_d = load_words_q;
    err_d        = err_q;
    mem_we       = 1'b0;

    case (state_q)
      LD_IDLE: state_d = LD_LOAD;
      LD_LOAD: if (accept && ld_last) state_d = LD_RUN;
      LD_RUN:  state_d = LD_RUN;
      default: state_d = LD_IDLE;
    endcase

    // A full array drops further words and pins the pointer, so word 0 survives.
    if (pack_strobe) begin
      if (word_ptr_q == PTR_FULL) begin
        err_d[0] = 1'b1;
      end else begin
        mem_we     = 1'b1;
        word_ptr_d = word_ptr_q + 1'b1;
      end
    end
    if (accept && ld_last) load_words_d = word_ptr_d;

    if (rom_ce && !hold_q && misaligned) err_d[1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= LD_IDLE;
      word_ptr_q   <= '0;
      load_words_q <= '0;
      err_q        <= 2'b00;
      hold_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      word_ptr_q   <= word_ptr_d;
      load_words_q <= load_words_d;
      err_q        <= err_d;
      hold_q       <= (state_q != LD_RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[word_ptr_q[DEPTH_LOG2-1:0]] <= pack_word;
  end

  // Fetch path is zero-latency; the window check uses unsigned 32-bit offset
  // so addresses below BASE_ADDR wrap high and fall out of range.
  assign offset     = rom_addr - BASE_ADDR;
  assign word_idx   = offset >> 2;
  assign misaligned = (rom_addr[1:0] != 2'b00);
  assign in_image   = (word_idx < 32'(load_words_q));

  always_comb begin
    rom_inst = ZERO_WORD;
    if (rom_ce) begin
      if (hold_q || misaligned || !in_image) rom_inst = NOP_INST;
      else                                   rom_inst = mem[word_idx[DEPTH_LOG2-1:0]];
    end
  end

  assign ld_ready   = (state_q == LD_LOAD);
  assign cpu_hold   = hold_q;
  assign load_words = load_words_q;
  assign err_flags  = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_inst_rom_server.sv
// Directed bench for inst_rom_server: a small instance (4 words, base 0) and a
// default-depth instance (base 0x1000) share stimulus and are checked each cycle.
module tb_inst_rom_server;
  import inst_rom_server_pkg::*;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] BASE_W = 32'h0000_1000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ce = 1'b0;
  logic [31:0] rom_addr = 32'h0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = 8'h0;
  logic        ld_last = 1'b0;

  logic [31:0] inst_s, inst_w;
  logic        rdy_s, rdy_w, hold_s, hold_w;
  logic [2:0]  lw_s;
  logic [10:0] lw_w;
  logic [1:0]  err_s, err_w;
  ld_state_e   st_s, st_w;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_rom_server #(.DEPTH_LOG2(2), .BASE_ADDR(32'h0)) dut_s (
    .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(inst_s),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(rdy_s),
    .cpu_hold(hold_s), .load_words(lw_s), .err_flags(err_s), .dbg_state(st_s)
  );

  inst_rom_server #(.DEPTH_LOG2(10), .BASE_ADDR(BASE_W)) dut_w (
    .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(inst_w),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(rdy_w),
    .cpu_hold(hold_w), .load_words(lw_w), .err_flags(err_w), .dbg_state(st_w)
  );

  // ---------------- behavioural model ----------------
  // Image bytes are collected as a stream; the visible array is rebuilt from
  // the whole image when the final byte arrives.
  logic [7:0]  m_bytes[$];
  bit          m_boot;
  bit          m_done;
  int          m_age;
  logic [31:0] m_mem_s[4];
  logic [31:0] m_mem_w[1024];
  int          m_lw[2];
  bit          m_ovf[2];
  bit          m_mis[2];

  function automatic bit m_hold();
    return !(m_done && m_age >= 1);
  endfunction

  function automatic logic [31:0] img_word(int i);
    logic [31:0] w = 32'h0;
    for (int j = 0; j < 4; j++)
      if (4 * i + j < m_bytes.size()) w[8*j +: 8] = m_bytes[4*i+j];
    return w;
  endfunction

  function automatic logic [31:0] exp_inst(int k);
    logic [31:0] off;
    logic [31:0] idx;
    if (!rom_ce) return 32'h0;
    if (m_hold() || rom_addr[1:0] != 2'b00) return NOP;
    off = rom_addr - ((k == 0) ? 32'h0 : BASE_W);
    idx = off >> 2;
    if (idx >= 32'(m_lw[k])) return NOP;
    return (k == 0) ? m_mem_s[idx[1:0]] : m_mem_w[idx[9:0]];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_bytes.delete();
      m_boot = 1'b1;
      m_done = 1'b0;
      m_age  = 0;
      m_lw   = '{0, 0};
      m_ovf  = '{1'b0, 1'b0};
      m_mis  = '{1'b0, 1'b0};
    end else begin
      bit hold_b;
      bit acc;
      int nw;
      hold_b = m_hold();
      acc    = !m_boot && !m_done && ld_valid;
      if (rom_ce && !hold_b && rom_addr[1:0] != 2'b00) m_mis = '{1'b1, 1'b1};
      if (m_done && m_age < 2) m_age++;
      m_boot = 1'b0;
      if (acc) begin
        m_bytes.push_back(ld_byte);
        nw = (m_bytes.size() + 3) / 4;
        if ((m_bytes.size() % 4 == 0) || ld_last) begin
          if (nw > 4)    m_ovf[0] = 1'b1;
          if (nw > 1024) m_ovf[1] = 1'b1;
        end
        if (ld_last) begin
          for (int i = 0; i < nw; i++) begin
            if (i < 4)    m_mem_s[i] = img_word(i);
            if (i < 1024) m_mem_w[i] = img_word(i);
          end
          m_lw[0] = (nw < 4) ? nw : 4;
          m_lw[1] = (nw < 1024) ? nw : 1024;
          m_done  = 1'b1;
          m_age   = 0;
          m_bytes.delete();
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("inst_s", inst_s, exp_inst(0));
    chk("inst_w", inst_w, exp_inst(1));
    chk("ready_s", 32'(rdy_s), 32'(!m_boot && !m_done));
    chk("ready_w", 32'(rdy_w), 32'(!m_boot && !m_done));
    chk("hold_s", 32'(hold_s), 32'(m_hold()));
    chk("hold_w", 32'(hold_w), 32'(m_hold()));
    chk("lw_s", 32'(lw_s), 32'(m_lw[0]));
    chk("lw_w", 32'(lw_w), 32'(m_lw[1]));
    chk("err_s", 32'(err_s), 32'({m_mis[0], m_ovf[0]}));
    chk("err_w", 32'(err_w), 32'({m_mis[1], m_ovf[1]}));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    int t = 0;
    while (!rdy_s && t < 20) begin
      tick();
      t++;
    end
    if (!rdy_s) chk("ready_timeout", 32'(rdy_s), 32'h1);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    rom_ce   = 1'b1;
    rom_addr = a;
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  logic [7:0] t1 [8];

  initial begin
    t1 = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};

    #2 rst = 1'b0;
    #1;
    chk("rst_hold", 32'(hold_s), 32'h1);
    chk("rst_ready", 32'(rdy_s), 32'h0);
    chk("rst_lw", 32'(lw_s), 32'h0);
    chk("rst_err", 32'(err_s), 32'h0);
    tick();
    tick();
    rst = 1'b1;

    // boot cycle and load phase: fetches must return NOP
    fetch(32'h0);
    chk("idle_fetch", inst_s, NOP);
    tick();
    chk("load_ready", 32'(rdy_s), 32'h1);
    for (int i = 0; i < 8; i++) begin
      send(t1[i], i == 7);
      if (i == 0) chk("load_fetch", inst_s, NOP);
    end
    chk("t1_lw", 32'(lw_s), 32'h2);
    chk("t1_hold_edge", 32'(hold_s), 32'h1);
    tick();
    chk("t1_hold_fall", 32'(hold_s), 32'h0);
    fetch(32'h0);    chk("t1_f0_s", inst_s, 32'h0010_0013); chk("t1_f0_w", inst_w, NOP);
    fetch(32'h4);    chk("t1_f4_s", inst_s, 32'h0020_0093);
    fetch(32'h1000); chk("t1_fb_w", inst_w, 32'h0010_0013); chk("t1_fb_s", inst_s, NOP);
    fetch(32'h1004); chk("t1_fb4_w", inst_w, 32'h0020_0093);
    fetch(32'h10);   chk("t1_beyond", inst_s, NOP);
    rom_ce = 1'b0;
    #1;
    chk("ce_off", inst_s, 32'h0);
    tick();

    // misaligned fetch in RUN
    fetch(32'h2);
    chk("mis_fetch", inst_s, NOP);
    tick();
    chk("mis_err", 32'(err_s), 32'h2);
    fetch(32'h0);

    // loader activity in RUN is ignored
    ld_valid = 1'b1;
    ld_byte  = 8'hff;
    ld_last  = 1'b1;
    #1;
    chk("run_ready", 32'(rdy_s), 32'h0);
    repeat (3) tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("run_keep", inst_s, 32'h0010_0013);
    chk("run_lw", 32'(lw_s), 32'h2);

    // partial final word is zero padded
    rst = 1'b0;
    tick();
    rst = 1'b1;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    send(8'haa, 1'b1);
    chk("t2_lw", 32'(lw_s), 32'h2);
    tick();
    fetch(32'h4); chk("t2_pad", inst_s, 32'h0000_00aa);
    fetch(32'h0); chk("t2_w0", inst_s, 32'h0403_0201);
    tick();

    // reset mid-load, then overflow the small instance
    rst = 1'b0;
    tick();
    rst = 1'b1;
    send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_ready", 32'(rdy_s), 32'h0);
    chk("mid_hold", 32'(hold_s), 32'h1);
    chk("mid_lw", 32'(lw_s), 32'h0);
    tick();
    rst = 1'b1;
    for (int j = 0; j < 20; j++) send(8'(j + 1), j == 19);
    chk("ovf_lw_s", 32'(lw_s), 32'h4);
    chk("ovf_err_s", 32'(err_s), 32'h1);
    chk("ovf_lw_w", 32'(lw_w), 32'h5);
    chk("ovf_err_w", 32'(err_w), 32'h0);
    tick();
    fetch(32'h0);    chk("ovf_w0", inst_s, 32'h0403_0201);
    fetch(32'hc);    chk("ovf_w3", inst_s, 32'h100f_0e0d);
    fetch(32'h10);   chk("ovf_w4_s", inst_s, NOP);
    fetch(32'h1010); chk("ovf_w4_w", inst_w, 32'h1413_1211);
    rom_ce = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
